l2_burst_responder: RTL and testbench
=====================================

Name: l2_burst_responder

Overview:
- Synthesizable L2-side read responder for the instruction cache's L2 port.
- Accepts one block-address request at a time on ADDR_TO_L2 and waits a fixed L2_DELAY.
- Then returns the block as L2_BURST consecutive beats of L2_BUS_WIDTH bits from an internal preloadable line memory.
- Honours the cache's DATA_FROM_L2_READY back-pressure as a global freeze.

Parameters:
- ADDR_WIDTH, 32, byte address width; request carries ADDR_WIDTH-2 word-address bits.
- B, 9, log2 block size in bits.
- W, 7, log2 L2 bus width in bits; L2_BUS_WIDTH = 1<<W, L2_BURST = 1<<(B-W).
- L2_DELAY, 7, enabled cycles from request acceptance to first valid beat; legal range 2..64.
- MEM_AW, 10, log2 number of L2_BUS_WIDTH-wide rows in the line memory.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- ADDR_TO_L2  in  ADDR_WIDTH-2  word address of requested block; low B-5 bits ignored.
- ADDR_TO_L2_VALID  in  1  request present.
- ADDR_TO_L2_READY  out  1  responder can accept a request.
- DATA_FROM_L2  out  L2_BUS_WIDTH  beat data.
- DATA_FROM_L2_VALID  out  1  beat present.
- DATA_FROM_L2_READY  in  1  cache ready; low freezes the whole responder.
- PRELOAD_EN  in  1  line-memory write strobe.
- PRELOAD_ADDR  in  MEM_AW  row to write.
- PRELOAD_DATA  in  L2_BUS_WIDTH  row data.
- BUSY  out  1  high in WAIT or BURST.

Behaviour:
- Global enable: en = DATA_FROM_L2_READY.
  - en low: state, counters, DATA_FROM_L2, DATA_FROM_L2_VALID and memory read enable all hold.
  - Preload writes are not frozen.
- ADDR_TO_L2_READY = (state==IDLE) & en & ~RST; combinational.
- A request is accepted on an edge where VALID & READY.
- FSM IDLE:
  - On accept, latch row_base = ADDR_TO_L2[ADDR_WIDTH-3 : B-5] << (B-W), truncated to MEM_AW.
  - Load dly = L2_DELAY-1, go to WAIT.
- FSM WAIT:
  - Decrement dly each enabled cycle.
  - When dly==1, issue synchronous read of row_base+0, go to BURST with beat=0.
- FSM BURST:
  - Each enabled cycle, register memory output onto DATA_FROM_L2 with VALID=1.
  - Issue read of row_base+beat+1 while beat < L2_BURST-1.
  - After beat L2_BURST-1 is presented, go to IDLE.
  - Beat order is always 0..L2_BURST-1; there is no critical-word-first.
- Timing: accept at enabled edge N → beats valid after enabled edges N+L2_DELAY .. N+L2_DELAY+L2_BURST-1, contiguous.
  - VALID drops on the following enabled edge.
- Overlap: a new request may be presented while the last beat is valid.
  - It is accepted only once state==IDLE, i.e. the edge after the last beat.
  - Minimum request spacing is L2_DELAY+L2_BURST enabled cycles.
- Row arithmetic: row_base+beat is MEM_AW wide and wraps modulo 2^MEM_AW; address bits above the memory size are dropped silently.
- Line memory:
  - One write port (preload) and one synchronous read port, read-first.
  - A same-row write and read in one cycle returns old data.
  - A write becomes visible to reads issued on later edges.
  - Contents are not affected by RST.
- Reset values:
  - DATA_FROM_L2=0, DATA_FROM_L2_VALID=0, BUSY=0, state=IDLE, dly=0, beat=0.
  - ADDR_TO_L2_READY=0 while RST high.
- Reset mid-WAIT or mid-BURST aborts the transfer immediately; no further beats; IDLE on the next cycle.
- DATA_FROM_L2 holds the last beat value when VALID is low; it is don't-care to the consumer.

Decomposition:
- Shared package l2_if_pkg:
  - ADDR_WIDTH, L2_BUS_WIDTH and L2_BURST derivation functions.
  - FSM state encoding (IDLE/WAIT/BURST).
  - Log2 helper.
- Sub-module l2_line_mem: simple-dual-port synchronous RAM (MEM_AW × L2_BUS_WIDTH) with read enable, read-first.
- FSM, counters and handshake live in l2_burst_responder.

Test Plan (defaults: L2_BURST=4, block = 16 words):
- Preload rows 4..7 with 0x…A4..0x…A7; request ADDR_TO_L2=0x0000010, READY held high → accepted at edge N; beats A4,A5,A6,A7 valid at edges N+7..N+10; VALID low at N+11.
- Same request with ADDR_TO_L2=0x0000017 (unaligned) → identical beats A4..A7 from row 4.
- Drop DATA_FROM_L2_READY for 3 cycles during beat 1 → DATA_FROM_L2=A5 and VALID held for 3 cycles; ADDR_TO_L2_READY=0; remaining beats follow with no loss or duplication.
- Keep VALID asserted continuously with two addresses → second accepted exactly one edge after the last beat of the first; ADDR_TO_L2_READY low throughout WAIT/BURST.
- Assert RST for one cycle during beat 2 → VALID=0 next cycle, no further beats, BUSY=0, and the next request is served normally with full L2_DELAY.
- Preload row 4 with 0x55 on the same edge the read of row 4 is issued → beat 0 returns old value; a repeat request returns 0x55.

Source files
------------

// File: rtl/l2_burst_responder_pkg.sv
// l2_if_pkg: shared definitions for the L2 burst responder slice.
//   - width/burst derivation helpers for the L2 port
//   - FSM state encoding used by the responder
//   - ceiling-log2 helper for counter sizing
package l2_if_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } l2_state_e;

    // Number of bits needed to hold values 0 .. v-1.
    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Requests carry a word address: byte address minus the two byte-offset bits.
    function automatic int l2_addr_word_w(input int addr_width);
        return addr_width - 2;
    endfunction

    function automatic int l2_bus_width(input int w);
        return 1 << w;
    endfunction

    function automatic int l2_burst(input int b, input int w);
        return 1 << (b - w);
    endfunction

endpackage

// File: rtl/l2_burst_responder_if.sv
// l2_burst_responder_if: request/response bus between the instruction cache
// and the L2 responder.
//   ADDR_TO_L2 / _VALID / _READY  : block request (cache -> L2)
//   DATA_FROM_L2 / _VALID         : beat data (L2 -> cache)
//   DATA_FROM_L2_READY            : cache ready; low freezes the responder
// master = cache side, slave = responder side.
interface l2_burst_responder_if
    import l2_if_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int L2_BUS_WIDTH = 128
);
    logic [l2_addr_word_w(ADDR_WIDTH)-1:0] ADDR_TO_L2;
    logic                                  ADDR_TO_L2_VALID;
    logic                                  ADDR_TO_L2_READY;
    logic [L2_BUS_WIDTH-1:0]               DATA_FROM_L2;
    logic                                  DATA_FROM_L2_VALID;
    logic                                  DATA_FROM_L2_READY;

    modport master (
        output ADDR_TO_L2, ADDR_TO_L2_VALID, DATA_FROM_L2_READY,
        input  ADDR_TO_L2_READY, DATA_FROM_L2, DATA_FROM_L2_VALID
    );

    modport slave (
        input  ADDR_TO_L2, ADDR_TO_L2_VALID, DATA_FROM_L2_READY,
        output ADDR_TO_L2_READY, DATA_FROM_L2, DATA_FROM_L2_VALID
    );
endinterface

// File: rtl/l2_burst_responder_line_mem.sv
// l2_line_mem: simple dual-port synchronous line memory.
//   clk_i                 : clock
//   wr_en_i/addr/data     : write port (preload), never gated
//   rd_en_i/rd_addr_i     : synchronous read request
//   rd_data_o             : registered read data, holds when rd_en_i is low
// Read-first: a same-row write and read on one edge returns the old row.
// Contents are deliberately not reset.
module l2_line_mem #(
    parameter int MEM_AW = 10,
    parameter int DW     = 128
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [MEM_AW-1:0] wr_addr_i,
    input  logic [DW-1:0]     wr_data_i,
    input  logic              rd_en_i,
    input  logic [MEM_AW-1:0] rd_addr_i,
    output logic [DW-1:0]     rd_data_o
);
    logic [DW-1:0] mem_q [2**MEM_AW];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/l2_burst_responder.sv
// l2_burst_responder: L2-side read responder for the instruction-cache port.
//   CLK, RST      : clock, synchronous active-high reset
//   bus (slave)   : request / beat handshake, see l2_burst_responder_if
//   PRELOAD_*     : line-memory write port, independent of back-pressure
//   BUSY          : high while waiting or bursting
// A request is answered after L2_DELAY enabled cycles with L2_BURST beats
// read in order from the line memory. DATA_FROM_L2_READY low freezes all
// state, outputs and the memory read port.
module l2_burst_responder
    import l2_if_pkg::*;
#(
    parameter  int ADDR_WIDTH   = 32,
    parameter  int B            = 9,
    parameter  int W            = 7,
    parameter  int L2_DELAY     = 7,
    parameter  int MEM_AW       = 10,
    localparam int L2_BUS_WIDTH = l2_bus_width(W)
) (
    input  logic                    CLK,
    input  logic                    RST,
    l2_burst_responder_if.slave     bus,
    input  logic                    PRELOAD_EN,
    input  logic [MEM_AW-1:0]       PRELOAD_ADDR,
    input  logic [L2_BUS_WIDTH-1:0] PRELOAD_DATA,
    output logic                    BUSY
);
    localparam int L2_BURST = l2_burst(B, W);
    localparam int BEAT_W   = (B - W) > 0 ? (B - W) : 1;
    localparam int DLY_W    = log2_ceil(L2_DELAY + 1);

    localparam logic [DLY_W-1:0]  DLY_INIT  = DLY_W'(L2_DELAY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(L2_BURST - 1);

    l2_state_e               state_q, state_d;
    logic [DLY_W-1:0]        dly_q, dly_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [MEM_AW-1:0]       row_base_q, row_base_d;
    logic [L2_BUS_WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;

    logic                    en;
    logic                    accept;
    logic [MEM_AW-1:0]       req_row;
    logic                    rd_en;
    logic [MEM_AW-1:0]       rd_addr;
    logic [L2_BUS_WIDTH-1:0] rd_data;

    assign en     = bus.DATA_FROM_L2_READY;
    assign accept = bus.ADDR_TO_L2_VALID & bus.ADDR_TO_L2_READY;

    // Drop the in-block word offset, scale block index to rows; address
    // bits beyond the memory size fall off in the truncation.
    assign req_row = MEM_AW'((bus.ADDR_TO_L2 >> (B - 5)) << (B - W));

    assign bus.ADDR_TO_L2_READY   = (state_q == S_IDLE) & en & ~RST;
    assign bus.DATA_FROM_L2       = data_q;
    assign bus.DATA_FROM_L2_VALID = valid_q;
    assign BUSY                   = (state_q != S_IDLE);

    l2_line_mem #(
        .MEM_AW (MEM_AW),
        .DW     (L2_BUS_WIDTH)
    ) u_mem (
        .clk_i     (CLK),
        .wr_en_i   (PRELOAD_EN),
        .wr_addr_i (PRELOAD_ADDR),
        .wr_data_i (PRELOAD_DATA),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        beat_d     = beat_q;
        row_base_d = row_base_q;
        data_d     = data_q;
        valid_d    = valid_q;
        rd_en      = 1'b0;
        rd_addr    = row_base_q;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    valid_d = 1'b0;
                    if (accept) begin
                        row_base_d = req_row;
                        dly_d      = DLY_INIT;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    dly_d = dly_q - DLY_W'(1);
                    // Read one cycle early so the first beat lands exactly
                    // L2_DELAY enabled edges after acceptance.
                    if (dly_q == DLY_W'(1)) begin
                        rd_en   = 1'b1;
                        rd_addr = row_base_q;
                        beat_d  = '0;
                        state_d = S_BURST;
                    end
                end
                S_BURST: begin
                    valid_d = 1'b1;
                    data_d  = rd_data;
                    if (beat_q == BEAT_LAST) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = row_base_q + MEM_AW'(beat_q) + MEM_AW'(1);
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            dly_q      <= '0;
            beat_q     <= '0;
            row_base_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            beat_q     <= beat_d;
            row_base_q <= row_base_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: tb/tb_l2_burst_responder.sv
// Directed bench for l2_burst_responder with default parameters
// (L2_DELAY=7, 4 beats of 128 bits, block = 16 words).
module tb_l2_burst_responder;
    localparam int AW  = 32;
    localparam int BW  = 128;
    localparam int MAW = 10;

    logic           CLK = 1'b0;
    logic           RST;
    logic           PRELOAD_EN;
    logic [MAW-1:0] PRELOAD_ADDR;
    logic [BW-1:0]  PRELOAD_DATA;
    logic           BUSY;

    int n_assert = 0;
    int n_fail   = 0;

    l2_burst_responder_if #(.ADDR_WIDTH(AW), .L2_BUS_WIDTH(BW)) bus ();

    l2_burst_responder #(
        .ADDR_WIDTH (AW),
        .B          (9),
        .W          (7),
        .L2_DELAY   (7),
        .MEM_AW     (MAW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (bus),
        .PRELOAD_EN   (PRELOAD_EN),
        .PRELOAD_ADDR (PRELOAD_ADDR),
        .PRELOAD_DATA (PRELOAD_DATA),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [BW-1:0] rv(input int r);
        return {32'hC0DE_0000 + 32'(r), 88'h0, 8'(8'hA0 + r)};
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input int r, input logic [BW-1:0] d);
        PRELOAD_EN   = 1'b1;
        PRELOAD_ADDR = MAW'(r);
        PRELOAD_DATA = d;
        tick();
        PRELOAD_EN   = 1'b0;
    endtask

    // Presents a request and lets it be accepted on the next edge.
    task automatic request(input logic [AW-3:0] a);
        bus.ADDR_TO_L2       = a;
        bus.ADDR_TO_L2_VALID = 1'b1;
        #1;
        check("req_ready", bus.ADDR_TO_L2_READY, 1'b1);
        tick();
        bus.ADDR_TO_L2_VALID = 1'b0;
        check("req_busy", BUSY, 1'b1);
        check("req_ready_low", bus.ADDR_TO_L2_READY, 1'b0);
    endtask

    // Six silent edges, then four contiguous beats.
    task automatic expect_burst(input logic [BW-1:0] e0, input logic [BW-1:0] e1,
                                input logic [BW-1:0] e2, input logic [BW-1:0] e3);
        logic [BW-1:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("wait_valid", bus.DATA_FROM_L2_VALID, 1'b0);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            check("beat_valid", bus.DATA_FROM_L2_VALID, 1'b1);
            check("beat_data", bus.DATA_FROM_L2, e[b]);
        end
    endtask

    task automatic expect_end();
        tick();
        check("end_valid", bus.DATA_FROM_L2_VALID, 1'b0);
        check("end_busy", BUSY, 1'b0);
    endtask

    initial begin
        RST                    = 1'b1;
        bus.ADDR_TO_L2         = '0;
        bus.ADDR_TO_L2_VALID   = 1'b0;
        bus.DATA_FROM_L2_READY = 1'b1;
        PRELOAD_EN             = 1'b0;
        PRELOAD_ADDR           = '0;
        PRELOAD_DATA           = '0;

        // Reset state
        tick();
        tick();
        check("rst_data", bus.DATA_FROM_L2, '0);
        check("rst_valid", bus.DATA_FROM_L2_VALID, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_ready", bus.ADDR_TO_L2_READY, 1'b0);
        RST = 1'b0;
        #1;
        check("post_rst_ready", bus.ADDR_TO_L2_READY, 1'b1);

        for (int r = 4; r < 12; r++) preload(r, rv(r));

        // Aligned request
        request(30'h0000010);
        expect_burst(rv(4), rv(5), rv(6), rv(7));
        expect_end();

        // Unaligned word address inside the same block
        request(30'h0000017);
        expect_burst(rv(4), rv(5), rv(6), rv(7));
        expect_end();

        // Back-pressure for three cycles during beat 1
        request(30'h0000010);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("stall_wait_valid", bus.DATA_FROM_L2_VALID, 1'b0);
        end
        tick();
        check("stall_b0", bus.DATA_FROM_L2, rv(4));
        tick();
        check("stall_b1", bus.DATA_FROM_L2, rv(5));
        bus.DATA_FROM_L2_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_data", bus.DATA_FROM_L2, rv(5));
            check("stall_hold_valid", bus.DATA_FROM_L2_VALID, 1'b1);
            check("stall_ready", bus.ADDR_TO_L2_READY, 1'b0);
            check("stall_busy", BUSY, 1'b1);
        end
        bus.DATA_FROM_L2_READY = 1'b1;
        tick();
        check("stall_b2", bus.DATA_FROM_L2, rv(6));
        check("stall_b2_valid", bus.DATA_FROM_L2_VALID, 1'b1);
        tick();
        check("stall_b3", bus.DATA_FROM_L2, rv(7));
        check("stall_b3_valid", bus.DATA_FROM_L2_VALID, 1'b1);
        expect_end();

        // Back-to-back requests with VALID held high
        bus.ADDR_TO_L2       = 30'h0000010;
        bus.ADDR_TO_L2_VALID = 1'b1;
        #1;
        check("b2b_ready0", bus.ADDR_TO_L2_READY, 1'b1);
        tick();
        bus.ADDR_TO_L2 = 30'h0000020;
        check("b2b_busy", BUSY, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("b2b_wait_valid", bus.DATA_FROM_L2_VALID, 1'b0);
            check("b2b_wait_ready", bus.ADDR_TO_L2_READY, 1'b0);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            check("b2b_data", bus.DATA_FROM_L2, rv(4 + b));
            check("b2b_valid", bus.DATA_FROM_L2_VALID, 1'b1);
            check("b2b_ready", bus.ADDR_TO_L2_READY, (b == 3) ? 1'b1 : 1'b0);
        end
        tick();
        bus.ADDR_TO_L2_VALID = 1'b0;
        check("b2b_second_valid", bus.DATA_FROM_L2_VALID, 1'b0);
        check("b2b_second_busy", BUSY, 1'b1);
        check("b2b_second_ready", bus.ADDR_TO_L2_READY, 1'b0);
        expect_burst(rv(8), rv(9), rv(10), rv(11));
        expect_end();

        // Reset while beat 2 is presented aborts the transfer
        request(30'h0000010);
        for (int i = 1; i <= 6; i++) tick();
        tick();
        check("abort_b0", bus.DATA_FROM_L2, rv(4));
        tick();
        tick();
        check("abort_b2", bus.DATA_FROM_L2, rv(6));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_valid", bus.DATA_FROM_L2_VALID, 1'b0);
        check("abort_busy", BUSY, 1'b0);
        check("abort_data", bus.DATA_FROM_L2, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_quiet", bus.DATA_FROM_L2_VALID, 1'b0);
        end
        request(30'h0000020);
        expect_burst(rv(8), rv(9), rv(10), rv(11));
        expect_end();

        // Preload on the same edge as the read of row 4: old value first
        request(30'h0000010);
        for (int i = 1; i <= 5; i++) tick();
        PRELOAD_EN   = 1'b1;
        PRELOAD_ADDR = MAW'(4);
        PRELOAD_DATA = 128'h55;
        tick();
        PRELOAD_EN   = 1'b0;
        check("rf_wait_valid", bus.DATA_FROM_L2_VALID, 1'b0);
        for (int b = 0; b < 4; b++) begin
            tick();
            check("rf_data", bus.DATA_FROM_L2, rv(4 + b));
        end
        expect_end();
        request(30'h0000010);
        expect_burst(128'h55, rv(5), rv(6), rv(7));
        expect_end();

        // Address bits above the memory size are dropped
        request(30'h0001010);
        expect_burst(128'h55, rv(5), rv(6), rv(7));
        expect_end();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
